alu_exec: RTL and testbench

Execution stage directly downstream of the 16 x 16-bit register file. It latches the two read-port operands A/B with an opcode and destination address, and computes the result. Single-cycle ops finish in one cycle; MUL runs as a 16-iteration shift-add sequence. The result goes back to the register file's write port as a one-cycle C/Caddr/load strobe, and Z/N/C/V flags are updated at the same time.

---
 rtl/kurm_alu_pkg.sv | 25 ++
 rtl/alu_exec_seq_multiplier.sv | 58 +++++
 rtl/alu_exec.sv | 152 +++++++++++++++
 tb/tb_alu_exec.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/kurm_alu_pkg.sv
// Shared definitions for the ALU execution stage: default widths,
// opcode encoding and FSM state encoding.
package kurm_alu_pkg;

    localparam int WIDTH = 16;
    localparam int AW    = 4;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOT  = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_SHR  = 4'd7;
    localparam logic [3:0] OP_MUL  = 4'd8;
    localparam logic [3:0] OP_PASS = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_WB   = 2'd2
    } state_t;

endpackage

// File: rtl/alu_exec_seq_multiplier.sv
// Unsigned shift-add multiplier, one partial product per cycle.
// o_done is high during the last iteration cycle; o_product then already
// includes that final partial product, so the caller can latch it on the
// same edge the iteration completes.
module seq_multiplier #(
    parameter int W = kurm_alu_pkg::WIDTH
) (
    input  logic           clk,
    input  logic           clear,
    input  logic           i_start,
    input  logic [W-1:0]   i_a,
    input  logic [W-1:0]   i_b,
    output logic           o_done,
    output logic [2*W-1:0] o_product
);
    localparam int         CW       = $clog2(W);
    localparam logic [CW-1:0] CNT_INIT = CW'(W - 1);

    logic [2*W-1:0] r_mcand;
    logic [W-1:0]   r_mplier;
    logic [2*W-1:0] r_acc;
    logic [CW-1:0]  r_cnt;
    logic           r_active;
    logic [2*W-1:0] w_addend;
    logic [2*W-1:0] w_acc_next;

    assign w_addend   = r_mplier[0] ? r_mcand : '0;
    assign w_acc_next = r_acc + w_addend;
    assign o_done     = r_active && (r_cnt == '0);
    assign o_product  = w_acc_next;

    // Operand capture on start, then one shift-add step per cycle until the count expires
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else if (i_start && !r_active) begin
            r_mcand  <= {{W{1'b0}}, i_a};
            r_mplier <= i_b;
            r_acc    <= '0;
            r_cnt    <= CNT_INIT;
            r_active <= 1'b1;
        end else if (r_active) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            if (r_cnt == '0) begin
                r_active <= 1'b0;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_exec.sv
// ALU execution stage: single-cycle ops computed at acceptance, MUL handed
// to the sequential multiplier. Results leave as a one-cycle writeback
// strobe with registered data, address and status flags.
module alu_exec
    import kurm_alu_pkg::*;
#(
    parameter int WIDTH = kurm_alu_pkg::WIDTH,
    parameter int AW    = kurm_alu_pkg::AW
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [AW-1:0]    dest,
    output logic             busy,
    output logic [WIDTH-1:0] C,
    output logic [AW-1:0]    Caddr,
    output logic             load,
    output logic             zero,
    output logic             neg,
    output logic             carry,
    output logic             ovf
);
    state_t             r_state;
    logic               r_busy;
    logic [WIDTH-1:0]   r_c;
    logic [AW-1:0]      r_caddr;
    logic [AW-1:0]      r_mul_dest;
    logic               r_load;
    logic               r_zero, r_neg, r_carry, r_ovf;

    logic               w_accept;
    logic               w_mul_start;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH-1:0]   w_res;
    logic               w_cy;
    logic               w_ov;
    logic               w_valid;

    // A start is only honoured while no MUL is iterating
    assign w_accept    = start && (r_state != ST_MUL);
    assign w_mul_start = w_accept && (op == OP_MUL);

    seq_multiplier #(.W(WIDTH)) u_mul (
        .clk       (clk),
        .clear     (clear),
        .i_start   (w_mul_start),
        .i_a       (A),
        .i_b       (B),
        .o_done    (w_mul_done),
        .o_product (w_prod)
    );

    assign w_sum  = {1'b0, A} + {1'b0, B};
    assign w_diff = A - B;

    // Single-cycle result, carry and overflow for the opcode presented with start
    always_comb begin
        w_valid = 1'b1;
        w_res   = '0;
        w_cy    = 1'b0;
        w_ov    = 1'b0;
        case (op)
            OP_ADD: begin
                w_res = w_sum[WIDTH-1:0];
                w_cy  = w_sum[WIDTH];
                w_ov  = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                w_res = w_diff;
                w_cy  = (A < B);
                w_ov  = (A[WIDTH-1] != B[WIDTH-1]) && (w_diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND:  w_res = A & B;
            OP_OR:   w_res = A | B;
            OP_XOR:  w_res = A ^ B;
            OP_NOT:  w_res = ~A;
            OP_SHL:  w_res = A << B[3:0];
            OP_SHR:  w_res = A >> B[3:0];
            OP_PASS: w_res = B;
            default: w_valid = 1'b0;
        endcase
    end

    // Control FSM with registered writeback strobe, data, address and flags
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_c        <= '0;
            r_caddr    <= '0;
            r_mul_dest <= '0;
            r_load     <= 1'b0;
            r_zero     <= 1'b0;
            r_neg      <= 1'b0;
            r_carry    <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_load <= 1'b0;
            case (r_state)
                ST_IDLE, ST_WB: begin
                    r_state <= ST_IDLE;
                    if (w_accept) begin
                        if (op == OP_MUL) begin
                            r_state    <= ST_MUL;
                            r_busy     <= 1'b1;
                            r_mul_dest <= dest;
                        end else if (w_valid) begin
                            r_state <= ST_WB;
                            r_load  <= 1'b1;
                            r_c     <= w_res;
                            r_caddr <= dest;
                            r_zero  <= (w_res == '0);
                            r_neg   <= w_res[WIDTH-1];
                            r_carry <= w_cy;
                            r_ovf   <= w_ov;
                        end
                    end
                end
                ST_MUL: begin
                    if (w_mul_done) begin
                        r_state <= ST_WB;
                        r_busy  <= 1'b0;
                        r_load  <= 1'b1;
                        r_c     <= w_prod[WIDTH-1:0];
                        r_caddr <= r_mul_dest;
                        r_zero  <= (w_prod[WIDTH-1:0] == '0);
                        r_neg   <= w_prod[WIDTH-1];
                        r_carry <= |w_prod[2*WIDTH-1:WIDTH];
                        r_ovf   <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy  = r_busy;
    assign C     = r_c;
    assign Caddr = r_caddr;
    assign load  = r_load;
    assign zero  = r_zero;
    assign neg   = r_neg;
    assign carry = r_carry;
    assign ovf   = r_ovf;

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec with hand-computed expected values.
module tb_alu_exec;
    logic        clk = 1'b0;
    logic        clear;
    logic        start;
    logic [3:0]  op;
    logic [15:0] A, B;
    logic [3:0]  dest;
    logic        busy, load, zero, neg, carry, ovf;
    logic [15:0] C;
    logic [3:0]  Caddr;

    int n_checks = 0;
    int n_errors = 0;
    int k;
    int busy_cnt;
    int load_cnt;

    alu_exec dut (
        .clk   (clk),
        .clear (clear),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .dest  (dest),
        .busy  (busy),
        .C     (C),
        .Caddr (Caddr),
        .load  (load),
        .zero  (zero),
        .neg   (neg),
        .carry (carry),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; sampling happens 1 ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] d);
        start = 1'b1; op = o; A = a; B = b; dest = d;
        tick();
        start = 1'b0;
    endtask

    function automatic logic [3:0] flags();
        return {zero, neg, carry, ovf};
    endfunction

    initial begin
        clear = 1'b0; start = 1'b0; op = 4'd0; A = '0; B = '0; dest = '0;
        tick(); tick();
        chk("reset_outputs", {busy, load, C, Caddr, flags()}, 32'h0);
        clear = 1'b1;
        tick();

        // ADD 15+30 -> 45 to r4
        issue(4'd0, 16'd15, 16'd30, 4'd4);
        chk("add_load", load, 1);
        chk("add_c", C, 16'd45);
        chk("add_caddr", Caddr, 4'd4);
        chk("add_flags", flags(), 4'b0000);
        tick();
        chk("add_load_drop", load, 0);
        chk("add_c_hold", C, 16'd45);

        // SUB 5-7 -> 0xFFFE, neg and borrow
        issue(4'd1, 16'd5, 16'd7, 4'd1);
        chk("sub_c", C, 16'hFFFE);
        chk("sub_flags", flags(), 4'b0110);
        tick();

        // ADD 0x7FFF+1 -> signed overflow
        issue(4'd0, 16'h7FFF, 16'h0001, 4'd3);
        chk("ovf_c", C, 16'h8000);
        chk("ovf_flags", flags(), 4'b0101);
        tick();

        // MUL 300*250 with a stray start and operand change mid-flight
        issue(4'd8, 16'd300, 16'd250, 4'd2);
        k = 1; busy_cnt = 0;
        while (!load && k < 40) begin
            if (busy) busy_cnt++;
            if (k == 5) begin
                start = 1'b1; op = 4'd0; A = 16'd1; B = 16'd1; dest = 4'd9;
            end else begin
                start = 1'b0; A = 16'hDEAD; B = 16'hBEEF;
            end
            tick();
            k++;
        end
        start = 1'b0;
        chk("mul_latency", k, 17);
        chk("mul_busy_cycles", busy_cnt, 16);
        chk("mul_busy_at_load", busy, 0);
        chk("mul_c", C, 16'h24F8);
        chk("mul_caddr", Caddr, 4'd2);
        chk("mul_flags", flags(), 4'b0010);
        tick();
        chk("mul_no_extra_load", load, 0);

        // Back-to-back SHL, SHR, AND
        start = 1'b1; op = 4'd6; A = 16'h0001; B = 16'd15; dest = 4'd5;
        tick();
        chk("shl_load", load, 1);
        chk("shl_c", {Caddr, C}, {4'd5, 16'h8000});
        chk("shl_flags", flags(), 4'b0100);
        op = 4'd7; A = 16'h8000; B = 16'd15; dest = 4'd6;
        tick();
        chk("shr_load", load, 1);
        chk("shr_c", {Caddr, C}, {4'd6, 16'h0001});
        chk("shr_flags", flags(), 4'b0000);
        op = 4'd2; A = 16'h00F0; B = 16'h0F00; dest = 4'd7;
        tick();
        start = 1'b0;
        chk("and_load", load, 1);
        chk("and_c", {Caddr, C}, {4'd7, 16'h0000});
        chk("and_flags", flags(), 4'b1000);
        tick();
        chk("b2b_load_drop", load, 0);

        // Invalid opcode after a SUB: nothing changes
        issue(4'd1, 16'd5, 16'd7, 4'd1);
        issue(4'd15, 16'd3, 16'd3, 4'd12);
        chk("inv_load", load, 0);
        chk("inv_flags", flags(), 4'b0110);
        chk("inv_c_hold", {Caddr, C}, {4'd1, 16'hFFFE});
        tick();
        chk("inv_load_later", {busy, load}, 2'b00);

        // Reset at cycle 8 of a MUL
        issue(4'd8, 16'd3, 16'd4, 4'd8);
        for (int i = 0; i < 7; i++) tick();
        chk("mid_mul_busy", busy, 1);
        clear = 1'b0;
        #1;
        chk("mid_mul_reset", {busy, load, C, Caddr, flags()}, 32'h0);
        tick();
        clear = 1'b1;
        load_cnt = 0;
        for (int i = 0; i < 25; i++) begin
            if (load || busy) load_cnt++;
            tick();
        end
        chk("aborted_no_load", load_cnt, 0);
        issue(4'd0, 16'd2, 16'd3, 4'd10);
        chk("post_reset_add", {load, Caddr, C}, {1'b1, 4'd10, 16'd5});
        chk("post_reset_flags", flags(), 4'b0000);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
